// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
//
// Word-organised data memory for the MEM stage of the pipelined CPU.
// A fixed address window [BASE_ADDR .. BASE_ADDR + 2^ADDR_BITS - 1] is mapped
// onto an internal array of DATA_W-bit words. Every address inside the window
// selects its own full word: there are no byte lanes and no alignment logic.
//
// Reads are combinational. Writes happen on the rising clock edge when the
// write strobe is high and the address is inside the window. Accesses outside
// the window raise addr_err, read back as all-X and never touch storage.
//
// Ports:
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous, active-high reset (clears all words)
//   sig_mem_write in   1       write strobe, sampled at the rising clk edge
//   addr          in   32      word address
//   write_data    in   DATA_W  data to store
//   read_data     out  DATA_W  word at addr (combinational, X when out of window)
//   addr_err      out  1       high when addr lies outside the window
//
// Handshake: there is no valid/ready pair. A read is "valid" in the same cycle
// addr is presented; a write is committed at the rising edge where
// sig_mem_write=1, rst=0 and addr_err=0. Nothing is ever back-pressured.
// ---------------------------------------------------------------------------
module data_mem #(
    parameter logic [31:0] BASE_ADDR = 32'h7FF00000,
    parameter int          ADDR_BITS = 20,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              addr_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [31:0]          offset;
    logic                 in_range;
    logic [ADDR_BITS-1:0] idx;

    // Distance of addr from the bottom of the window. Once addr >= BASE_ADDR
    // the subtraction cannot underflow, so "addr <= top of window" is the
    // same as "offset has no bits set at or above ADDR_BITS". Testing the
    // offset this way also avoids forming BASE_ADDR + 2^ADDR_BITS, which
    // could overflow 32 bits for windows that end at the top of the map.
    assign offset   = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (offset[31:ADDR_BITS] == '0);
    assign idx      = offset[ADDR_BITS-1:0];
    assign addr_err = !in_range;

    // Combinational read, no bypass: a word written at the next edge shows
    // its old value until that edge has passed.
    always_comb begin
        read_data = 'x;
        if (in_range) begin
            read_data = mem[idx];
        end
    end

    // Reset wins over a simultaneous write; the write is simply lost.
    // Out-of-window writes are dropped here and only reported via addr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (sig_mem_write && in_range) begin
            mem[idx] <= write_data;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// ---------------------------------------------------------------------------
// tb_data_mem
//
// Bench for data_mem. Inputs are driven on the falling edge; the expected
// read_data / addr_err for that cycle are computed from a sparse word model
// (associative array, absent entries read as zero) and pushed onto exp_q.
// A separate monitor samples the DUT just before the next rising edge and
// pops one expectation per cycle. The model is updated after the push, so a
// same-cycle write is correctly expected to appear only from the next cycle.
// ---------------------------------------------------------------------------
module tb_data_mem;

  localparam logic [31:0] WIN_LO = 32'h7FF00000;
  localparam logic [31:0] WIN_HI = 32'h7FFFFFFF;

  // ---------------- clock / reset block ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_mem_write = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        addr_err;

  always #5 clk = ~clk;

  data_mem dut (
    .clk           (clk),
    .rst           (rst),
    .sig_mem_write (sig_mem_write),
    .addr          (addr),
    .write_data    (write_data),
    .read_data     (read_data),
    .addr_err      (addr_err)
  );

  // ---------------- reference model ----------------
  logic [31:0] model [logic [31:0]];
  bit          model_known = 1'b0;

  function automatic bit in_window(input logic [31:0] a);
    return (a >= WIN_LO) && (a <= WIN_HI);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return 32'h0;
  endfunction

  // ---------------- scoreboard ----------------
  // entry = {check_data, expected_err, expected_data, addr}
  logic [65:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;

  always @(negedge clk) begin
    logic [65:0] e;
    #4;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (addr_err !== e[64]) begin
        mismatched++;
        $display("FAIL addr_err @%h: got %b want %b", e[31:0], addr_err, e[64]);
      end
      if (e[65]) begin
        compared++;
        if (read_data !== e[63:32]) begin
          mismatched++;
          $display("FAIL read_data @%h: got %h want %h", e[31:0], read_data, e[63:32]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    bit inw;
    @(negedge clk);
    rst = r;
    sig_mem_write = we;
    addr = a;
    write_data = d;
    inw = in_window(a);
    // Out-of-window data is X, which a 2-state simulator cannot show, so
    // only addr_err is checked there.
    exp_q.push_back({(inw && model_known), !inw, model_read(a), a});
    if (r) begin
      model.delete();
      model_known = 1'b1;
    end else if (we && inw) begin
      model[a] = d;
    end
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b0, a, $urandom());
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] hot [16];

  function automatic logic [31:0] pick_addr();
    int sel;
    logic [31:0] edge_tbl [8];
    edge_tbl = '{32'h7FF00000, 32'h7FF00001, 32'h7FFFFFFE, 32'h7FFFFFFF,
                 32'h7FEFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
    sel = $urandom_range(0, 9);
    if (sel < 5) return hot[$urandom_range(0, 15)];
    if (sel < 8) return edge_tbl[$urandom_range(0, 7)];
    if (sel == 8) return WIN_LO + ($urandom() & 32'h000FFFFF);
    return $urandom();
  endfunction

  initial begin
    int waited;
    for (int i = 0; i < 16; i++) hot[i] = WIN_LO + ($urandom() & 32'h000FFFFF);

    // Reset, then the directed plan.
    cyc(1'b1, 1'b0, 32'h7FFFFFFF, 32'h0);
    rd(32'h7FFFFFFF);
    wr(32'h7FFFFFFE, 32'hDEADBEEF);
    rd(32'h7FFFFFFE);
    rd(32'h7FFFFFFF);
    wr(32'h7FFFFFFF, 32'h12345678);
    rd(32'h7FFFFFFF);
    rd(32'h7FFFFFFE);
    cyc(1'b0, 1'b0, 32'h7FFFFFFE, 32'h0000DEAD);
    cyc(1'b0, 1'b0, 32'h7FFFFFFF, 32'hBEEF0000);
    rd(32'h7FFFFFFE);
    rd(32'h7FFFFFFF);
    wr(32'h7FEFFFFF, 32'hCAFEF00D);
    wr(32'h80000000, 32'hCAFEF00D);
    rd(32'h7FF00000);
    rd(32'h7FFFFFFE);
    rd(32'h7FFFFFFF);
    // The low end of the window must not alias with the high end.
    wr(32'h7FF00000, 32'hA5A5A5A5);
    rd(32'h7FFFFFFF);
    rd(32'h7FF00000);
    // Reset together with a write: the write is lost.
    cyc(1'b1, 1'b1, 32'h7FF00000, 32'h11111111);
    rd(32'h7FF00000);
    rd(32'h7FFFFFFE);
    rd(32'h7FFFFFFF);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 2) cyc(1'b1, 1'($urandom_range(0, 1)), pick_addr(), $urandom());
      else if (k < 45) wr(pick_addr(), $urandom());
      else rd(pick_addr());
    end

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    rst = 1'b0;
    sig_mem_write = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #6;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
